rv32_multicycle_core: RTL and testbench

//  Parametrised multi-cycle RV32I-subset core: next generation of the team's single-cycle load/store CPU.

---
 rtl/rv32_pkg.sv | 59 +++++
 rtl/rv32_alu.sv | 33 +++
 rtl/rv32_multicycle_core.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_rv32_multicycle_core.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset core.
// Holds the opcode and funct3 encodings, the ALU operation set and the
// control FSM state type used by rv32_multicycle_core and rv32_alu.
package rv32_pkg;

    // Major opcodes handled by the core; anything else halts it.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 codes for OP / OP-IMM.
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 codes for loads and stores.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct7 values that are legal for R-type and shift-immediate forms.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_LOAD,
        ST_STORE,
        ST_HALT
    } state_t;

endpackage

// File: rtl/rv32_alu.sv
// Combinational 32-bit ALU shared by OP and OP-IMM (and LUI via pass-b).
// Ports:
//   a, b    : operands (b is rs2 or the decoded immediate)
//   alu_op  : operation select
//   result  : 32-bit result, add/sub wrap modulo 2^32
module rv32_alu
    import rv32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = a + b;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {31'b0, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = a + b;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I-subset core: LOAD, STORE, OP, OP-IMM and LUI executed
// through a fetch/exec/mem FSM. Illegal encodings, out-of-range register
// indices and misaligned accesses stop the core in a sticky halt state.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   iaddr      : instruction byte address (pc)
//   idata      : instruction word at iaddr, combinational
//   daddr      : word-aligned data address, 0 outside load/store cycles
//   drdata     : data word at daddr, combinational
//   dwdata     : lane-replicated store data, 0 outside store cycle
//   dwe        : byte write enables, pulsed only in the store cycle
//   halted     : sticky fault indicator
module rv32_multicycle_core
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    output logic [31:0] daddr,
    input  logic [31:0] drdata,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    output logic        halted
);

    localparam int         IDX_W = $clog2(NUM_REGS);
    localparam logic [5:0] NREG  = 6'(NUM_REGS);

    state_t      state, state_next;
    logic [31:0] pc, ir, ea;
    logic [31:0] regs [NUM_REGS];

    // Instruction fields
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_u;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_u  = {ir[31:12], 12'b0};

    function automatic logic idx_ok(input logic [4:0] idx);
        return {1'b0, idx} < NREG;
    endfunction

    // x0 and out-of-range indices read as zero; out-of-range ones halt in EXEC anyway.
    logic [31:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0 || !idx_ok(rs1)) ? 32'd0 : regs[rs1[IDX_W-1:0]];
    assign rs2_val = (rs2 == 5'd0 || !idx_ok(rs2)) ? 32'd0 : regs[rs2[IDX_W-1:0]];

    // Decode: legality, ALU control, effective address and alignment.
    logic        legal, is_load, is_store, uses_rd, uses_rs1, uses_rs2;
    logic        misaligned;
    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_result, ea_next;

    always_comb begin
        legal    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        alu_op   = ALU_ADD;
        alu_b    = rs2_val;
        case (funct3)
            F3_ADD:  alu_op = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
        case (opcode)
            OPC_OP: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                legal    = (funct7 == F7_BASE) ||
                           (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
            end
            OPC_OP_IMM: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                alu_b    = imm_i;
                // Shift-immediates carry funct7 in the immediate; a set ir[25] would be shamt[5].
                if (funct3 == F3_SLL)
                    legal = (funct7 == F7_BASE);
                else if (funct3 == F3_SR)
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else
                    legal = 1'b1;
            end
            OPC_LUI: begin
                uses_rd = 1'b1;
                alu_op  = ALU_PASSB;
                alu_b   = imm_u;
                legal   = 1'b1;
            end
            OPC_LOAD: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                is_load  = 1'b1;
                legal    = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                           (funct3 == F3_LBU) || (funct3 == F3_LHU);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                is_store = 1'b1;
                legal    = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
            end
            default: legal = 1'b0;
        endcase
        if ((uses_rd && !idx_ok(rd)) || (uses_rs1 && !idx_ok(rs1)) || (uses_rs2 && !idx_ok(rs2)))
            legal = 1'b0;
    end

    assign ea_next = rs1_val + (is_store ? imm_s : imm_i);

    // funct3[1:0] encodes access size for both loads and stores.
    always_comb begin
        case (funct3[1:0])
            2'b10:   misaligned = (ea_next[1:0] != 2'b00);
            2'b01:   misaligned = ea_next[0];
            default: misaligned = 1'b0;
        endcase
    end

    rv32_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result)
    );

    // Load extender: shift the addressed lane down to bit 0, then extend.
    logic [31:0] lane_word, load_val;
    assign lane_word = drdata >> {ea[1:0], 3'b000};

    always_comb begin
        case (funct3)
            F3_LB:   load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            F3_LH:   load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            F3_LBU:  load_val = {24'b0, lane_word[7:0]};
            F3_LHU:  load_val = {16'b0, lane_word[15:0]};
            default: load_val = lane_word;
        endcase
    end

    // Store lanes: data replicated across the word, enables picked by ea[1:0].
    logic [31:0] store_data;
    logic [3:0]  store_mask;

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                store_data = {4{rs2_val[7:0]}};
                store_mask = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                store_data = {2{rs2_val[15:0]}};
                store_mask = 4'b0011 << ea[1:0];
            end
            default: begin
                store_data = rs2_val;
                store_mask = 4'b1111;
            end
        endcase
    end

    // FSM next-state and datapath control
    logic        ir_load, pc_inc, ea_load, rf_we, halt_set, store_cyc;
    logic [31:0] rf_wdata;

    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        ea_load    = 1'b0;
        rf_we      = 1'b0;
        rf_wdata   = alu_result;
        halt_set   = 1'b0;
        store_cyc  = 1'b0;
        case (state)
            ST_FETCH: begin
                ir_load    = 1'b1;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (!legal || ((is_load || is_store) && misaligned)) begin
                    halt_set   = 1'b1;
                    state_next = ST_HALT;
                end else if (is_load) begin
                    ea_load    = 1'b1;
                    state_next = ST_LOAD;
                end else if (is_store) begin
                    ea_load    = 1'b1;
                    state_next = ST_STORE;
                end else begin
                    rf_we      = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_LOAD: begin
                rf_we      = 1'b1;
                rf_wdata   = load_val;
                pc_inc     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_STORE: begin
                store_cyc  = 1'b1;
                pc_inc     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_FETCH;
        else
            state <= state_next;
    end

    // Reset takes priority, so an instruction interrupted by reset never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= 32'd0;
            ea     <= 32'd0;
            halted <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 32'd0;
        end else begin
            if (ir_load)
                ir <= idata;
            if (ea_load)
                ea <= ea_next;
            if (pc_inc)
                pc <= pc + 32'd4;
            if (halt_set)
                halted <= 1'b1;
            if (rf_we && rd != 5'd0)
                regs[rd[IDX_W-1:0]] <= rf_wdata;
        end
    end

    // Memory-side outputs are gated by reset so the reset cycle itself is quiet.
    always_comb begin
        iaddr  = reset ? RESET_PC : pc;
        daddr  = 32'd0;
        dwdata = 32'd0;
        dwe    = 4'b0000;
        if (!reset && (state == ST_LOAD || state == ST_STORE))
            daddr = {ea[31:2], 2'b00};
        if (!reset && store_cyc) begin
            dwdata = store_data;
            dwe    = store_mask;
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench for rv32_multicycle_core: a small instruction ROM and a
// byte-writable data RAM surround the core; every store pulse is logged
// and compared against hand-computed expectations.
module tb_rv32_multicycle_core;

    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] LUIO = 7'b0110111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iaddr, idata, daddr, drdata, dwdata;
    logic [3:0]  dwe;
    logic        halted;

    logic [31:0] rom [64];
    logic [31:0] ram [16];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [31:0] s_addr [$];
    logic [31:0] s_data [$];
    logic [3:0]  s_we   [$];
    int          s_cyc  [$];

    rv32_multicycle_core #(
        .RESET_PC (32'h0000_0000),
        .NUM_REGS (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .iaddr  (iaddr),
        .idata  (idata),
        .daddr  (daddr),
        .drdata (drdata),
        .dwdata (dwdata),
        .dwe    (dwe),
        .halted (halted)
    );

    always #5 clk = ~clk;

    assign idata  = rom[iaddr[7:2]];
    assign drdata = ram[daddr[5:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (dwe[i])
                ram[daddr[5:2]][8*i +: 8] <= dwdata[8*i +: 8];
    end

    always @(posedge clk) begin
        if (reset)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (dwe != 4'b0000) begin
            s_addr.push_back(daddr);
            s_data.push_back(dwdata);
            s_we.push_back(dwe);
            s_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", tag, actual, expected);
        end
    endtask

    // Loads a program, clears memory and the store log, and pulses reset.
    task automatic applyStimulus(input int prog);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        for (int i = 0; i < 16; i++) ram[i] = 32'd0;
        case (prog)
            1: begin
                rom[0]  = enc_i(OPI, 5'd1, 3'b000, 5'd0, 12'hFFB);
                rom[1]  = enc_i(OPI, 5'd2, 3'b000, 5'd0, 12'd3);
                rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
                rom[3]  = enc_s(12'd4, 5'd3, 5'd0, 3'b010);
                rom[4]  = enc_i(LD, 5'd4, 3'b000, 5'd0, 12'd4);
                rom[5]  = enc_i(LD, 5'd5, 3'b100, 5'd0, 12'd4);
                rom[6]  = enc_s(12'd8, 5'd4, 5'd0, 3'b010);
                rom[7]  = enc_s(12'd12, 5'd5, 5'd0, 3'b010);
                rom[8]  = enc_s(12'd6, 5'd2, 5'd0, 3'b000);
                rom[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd8);
                rom[10] = enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd9);
                rom[11] = enc_i(OPI, 5'd7, 3'b101, 5'd1, 12'h401);
                rom[12] = enc_i(OPI, 5'd0, 3'b000, 5'd0, 12'd7);
                rom[13] = enc_s(12'd16, 5'd8, 5'd0, 3'b010);
                rom[14] = enc_s(12'd20, 5'd9, 5'd0, 3'b010);
                rom[15] = enc_s(12'd24, 5'd7, 5'd0, 3'b010);
                rom[16] = enc_s(12'd28, 5'd0, 5'd0, 3'b010);
                rom[17] = enc_i(LD, 5'd10, 3'b010, 5'd0, 12'd4);
                rom[18] = enc_s(12'd32, 5'd10, 5'd0, 3'b010);
                rom[19] = enc_i(LD, 5'd11, 3'b001, 5'd0, 12'd6);
                rom[20] = enc_s(12'd2, 5'd11, 5'd0, 3'b001);
                rom[21] = enc_i(LD, 5'd12, 3'b101, 5'd0, 12'd6);
                rom[22] = enc_r(7'h20, 5'd2, 5'd12, 3'b000, 5'd13);
                rom[23] = enc_s(12'd36, 5'd13, 5'd0, 3'b010);
                rom[24] = {20'h12345, 5'd14, LUIO};
                rom[25] = enc_i(OPI, 5'd15, 3'b100, 5'd14, 12'hFFF);
                rom[26] = enc_s(12'd40, 5'd15, 5'd0, 3'b010);
                rom[27] = enc_r(7'h00, 5'd2, 5'd2, 3'b001, 5'd16);
                rom[28] = enc_s(12'd44, 5'd16, 5'd0, 3'b010);
            end
            2: begin
                rom[0] = enc_i(OPI, 5'd6, 3'b000, 5'd0, 12'd9);
                rom[1] = enc_i(LD, 5'd6, 3'b010, 5'd0, 12'd2);
            end
            3: rom[0] = enc_s(12'd5, 5'd0, 5'd0, 3'b001);
            4: rom[0] = enc_i(OPI, 5'd1, 3'b001, 5'd0, 12'h021);
            default: rom[0] = enc_s(12'd0, 5'd0, 5'd0, 3'b010);
        endcase
        s_addr.delete();
        s_data.delete();
        s_we.delete();
        s_cyc.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput($sformatf("p%0d_rst_iaddr", prog), iaddr, 32'h0000_0000);
        checkOutput($sformatf("p%0d_rst_halted", prog), {31'b0, halted}, 32'd0);
        checkOutput($sformatf("p%0d_rst_dwe", prog), {28'b0, dwe}, 32'd0);
        checkOutput($sformatf("p%0d_rst_daddr", prog), daddr, 32'd0);
        checkOutput($sformatf("p%0d_rst_dwdata", prog), dwdata, 32'd0);
        reset = 1'b0;
    endtask

    task automatic waitHalt(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) begin
                at_cyc = cyc;
                break;
            end
        end
        checkOutput("halt_reached", {31'b0, halted}, 32'd1);
    endtask

    logic [31:0] exp_addr [13];
    logic [31:0] exp_data [13];
    logic [3:0]  exp_we   [13];

    initial begin
        int hc;
        $display("[TB] start");

        // Program 1: ALU ops, sub-word loads/stores, x0 handling
        exp_addr = '{32'd4, 32'd8, 32'd12, 32'd4, 32'd16, 32'd20, 32'd24,
                     32'd28, 32'd32, 32'd0, 32'd36, 32'd40, 32'd44};
        exp_data = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_00FE, 32'h0303_0303,
                     32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0000,
                     32'hFF03_FFFE, 32'hFF03_FF03, 32'h0000_FF00, 32'hEDCB_AFFF,
                     32'h0000_0018};
        exp_we   = '{4'hF, 4'hF, 4'hF, 4'h4, 4'hF, 4'hF, 4'hF,
                     4'hF, 4'hF, 4'hC, 4'hF, 4'hF, 4'hF};
        applyStimulus(1);
        waitHalt(300, hc);
        checkOutput("p1_halt_cycle", 32'(hc), 32'd78);
        checkOutput("p1_halt_pc", iaddr, 32'd116);
        checkOutput("p1_store_count", 32'(s_addr.size()), 32'd13);
        if (s_cyc.size() > 0)
            checkOutput("p1_first_store_cycle", 32'(s_cyc[0]), 32'd8);
        for (int i = 0; i < 13; i++) begin
            if (i < s_addr.size()) begin
                checkOutput($sformatf("p1_st%0d_addr", i), s_addr[i], exp_addr[i]);
                checkOutput($sformatf("p1_st%0d_data", i), s_data[i], exp_data[i]);
                checkOutput($sformatf("p1_st%0d_we", i), {28'b0, s_we[i]}, {28'b0, exp_we[i]});
            end
        end

        // Program 2: misaligned LW halts with no access and no RF write
        applyStimulus(2);
        waitHalt(50, hc);
        checkOutput("p2_halt_cycle", 32'(hc), 32'd4);
        repeat (5) @(negedge clk);
        checkOutput("p2_iaddr_frozen", iaddr, 32'd4);
        checkOutput("p2_daddr_idle", daddr, 32'd0);
        checkOutput("p2_store_count", 32'(s_addr.size()), 32'd0);
        checkOutput("p2_x6_kept", dut.regs[6], 32'd9);

        // Program 3: misaligned SH halts without a write pulse
        applyStimulus(3);
        waitHalt(50, hc);
        checkOutput("p3_halt_cycle", 32'(hc), 32'd2);
        repeat (3) @(negedge clk);
        checkOutput("p3_iaddr_frozen", iaddr, 32'd0);
        checkOutput("p3_store_count", 32'(s_addr.size()), 32'd0);

        // Program 4: SLLI with ir[25] set is illegal
        applyStimulus(4);
        waitHalt(50, hc);
        checkOutput("p4_halt_cycle", 32'(hc), 32'd2);
        checkOutput("p4_halt_pc", iaddr, 32'd0);

        // Program 5: reset asserted during the store cycle suppresses the pulse
        applyStimulus(5);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 checkOutput("p5_dwe_in_reset", {28'b0, dwe}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("p5_iaddr_after_reset", iaddr, 32'h0000_0000);
        checkOutput("p5_halted_after_reset", {31'b0, halted}, 32'd0);
        waitHalt(50, hc);
        checkOutput("p5_store_count", 32'(s_addr.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
